rr_grant_arbiter: RTL

Round-robin arbiter that shares one resource, such as a bus master port or a shared peripheral, between `N_REQ` requesters. It issues a registered one-hot grant and holds it until the resource signals `release`. It then re-arbitrates with no bubble cycle. Priority rotates so that the most recently served requester becomes lowest priority. An optional hold-timeout revokes a grant that has been held too long.

---
 rtl/rr_arb_pkg.sv | 12 +
 rtl/rr_mask_select.sv | 33 +++
 rtl/rr_grant_arbiter.sv | 98 +++++++++
 3 files changed

// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin grant arbiter: FSM state encoding
// and the width of the optional hold counter.
package rr_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_e;

  localparam int W_HOLD = 16;

endpackage : rr_arb_pkg

// File: rtl/rr_mask_select.sv
// Combinational round-robin winner selection: first request strictly above the
// last-served requester, wrapping to the lowest request when none is above.
module rr_mask_select #(
  parameter int N_REQ = 4,
  parameter int W_IDX = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] last_i,
  output logic [N_REQ-1:0] win_o,
  output logic [W_IDX-1:0] win_idx_o
);

  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  logic [N_REQ-1:0] mask;
  logic [N_REQ-1:0] masked;
  logic [N_REQ-1:0] cand;

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    win_idx_o = '0;
    // (last << 1) - 1 covers last and everything below it; the top bit of
    // last shifts out, giving an empty mask and forcing the wrap-around.
    mask      = ~((last_i << 1) - ONE);
    masked    = req_i & mask;
    cand      = (|masked) ? masked : req_i;
    win_o     = cand & (~cand + ONE);
    for (int i = 0; i < N_REQ; i++) begin
      if (win_o[i]) win_idx_o = W_IDX'(i);
    end
  end

endmodule : rr_mask_select

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with registered one-hot grant held until release.
// Define RR_ARB_TIMEOUT_EN to build the hold counter that revokes long grants.
module rr_grant_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int W_IDX    = $clog2(N_REQ),
  parameter int MAX_HOLD = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_i,
  input  logic             release_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic             gnt_valid_o,
  output logic [W_IDX-1:0] gnt_idx_o,
  output logic             timeout_o
);

  localparam logic [N_REQ-1:0] LAST_RST = {1'b1, {(N_REQ-1){1'b0}}};

  arb_state_e       state_q;
  logic [N_REQ-1:0] last_q;
  logic [N_REQ-1:0] gnt_q;
  logic [W_IDX-1:0] idx_q;
  logic             timeout_q;

  logic [N_REQ-1:0] win;
  logic [W_IDX-1:0] win_idx;
  logic             force_rel;
  logic             do_arb;

  rr_mask_select #(
    .N_REQ (N_REQ),
    .W_IDX (W_IDX)
  ) u_sel (
    .req_i     (req_i),
    .last_i    (last_q),
    .win_o     (win),
    .win_idx_o (win_idx)
  );

`ifdef RR_ARB_TIMEOUT_EN
  logic [W_HOLD-1:0] hold_q;

  // A real release in the same cycle takes precedence, so no timeout then.
  assign force_rel = (state_q == ARB_OWNED) && !release_i &&
                     (hold_q == W_HOLD'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else if (do_arb) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_q + 1'b1;
    end
  end
`else
  logic unused_cfg;

  assign force_rel  = 1'b0;
  assign unused_cfg = ^W_HOLD'(MAX_HOLD);
`endif

  // Idle always arbitrates; an owned grant only on release or timeout.
  assign do_arb = (state_q == ARB_IDLE) || release_i || force_rel;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      last_q    <= LAST_RST;
      gnt_q     <= '0;
      idx_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= force_rel;
      if (do_arb) begin
        if (|req_i) begin
          state_q <= ARB_OWNED;
          gnt_q   <= win;
          idx_q   <= win_idx;
          last_q  <= win;
        end else begin
          state_q <= ARB_IDLE;
          gnt_q   <= '0;
        end
      end
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_valid_o = |gnt_q;
  assign gnt_idx_o   = idx_q;
  assign timeout_o   = timeout_q;

endmodule : rr_grant_arbiter
